// File: rtl/iir_biquad_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_sequencer_pkg
// Brief    : Shared FSM states, coefficient-bank layout and sizing helpers
//            for the time-multiplexed biquad sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package iir_biquad_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_COMMIT = 3'd1;
    localparam state_t S_MAC    = 3'd2;
    localparam state_t S_ACC    = 3'd3;
    localparam state_t S_GAIN   = 3'd4;
    localparam state_t S_OUT    = 3'd5;

    // Accumulator carries three guard bits over the full product width
    function automatic int calc_acc_width(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    localparam int C_ACC_WIDTH  = calc_acc_width(32, 32);
    localparam int C_UNITY_GAIN = 65536;

    // Coefficient bank slot layout
    localparam int C_NUM_COEFF = 6;
    localparam int C_B0        = 0;
    localparam int C_B1        = 1;
    localparam int C_B2        = 2;
    localparam int C_A1        = 3;
    localparam int C_A2        = 4;
    localparam int C_GAIN      = 5;

endpackage
`default_nettype wire

// File: rtl/iir_shared_mult.sv
`default_nettype none
// ============================================================================
// Module   : iir_shared_mult
// Brief    : Signed A x B multiplier with a single output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module iir_shared_mult
    import iir_biquad_sequencer_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int B_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [A_WIDTH-1:0]         a,
    input  logic signed [B_WIDTH-1:0]         b,
    output logic signed [A_WIDTH+B_WIDTH-1:0] p
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
        end else begin
            p <= P_WIDTH'(a) * P_WIDTH'(b);
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_biquad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : iir_biquad_sequencer
// Brief    : Direct-form-I biquad on one shared multiplier, with a shadow
//            coefficient bank committed between samples. Optional macro
//            IIR_SAT_EN saturates y and y_out instead of wrapping them.
// Revision : 1.0 - initial release
// ============================================================================
module iir_biquad_sequencer
    import iir_biquad_sequencer_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int COEFF_WIDTH    = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LOG_A0         = 30
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [IN_DATA_WIDTH-1:0]  x_in,
    input  logic                             x_valid,
    output logic                             x_ready,
    input  logic signed [COEFF_WIDTH-1:0]    b0,
    input  logic signed [COEFF_WIDTH-1:0]    b1,
    input  logic signed [COEFF_WIDTH-1:0]    b2,
    input  logic signed [COEFF_WIDTH-1:0]    a1,
    input  logic signed [COEFF_WIDTH-1:0]    a2,
    input  logic signed [COEFF_WIDTH-1:0]    gain,
    input  logic                             coeff_load,
    output logic                             coeff_pending,
    input  logic                             hist_clr,
    output logic signed [OUT_DATA_WIDTH-1:0] y_out,
    output logic                             y_valid,
    output logic                             overrun,
    input  logic                             ovr_clr
);

    localparam int ACC_W   = calc_acc_width(DATA_WIDTH, COEFF_WIDTH);
    localparam int PROD_W  = DATA_WIDTH + COEFF_WIDTH;
    localparam int X_SHIFT = DATA_WIDTH - IN_DATA_WIDTH;

    state_t                          r_state;
    logic [2:0]                      r_step;
    logic                            r_run;
    logic                            r_pending;
    logic                            r_overrun;
    logic signed [COEFF_WIDTH-1:0]   r_shadow [C_NUM_COEFF];
    logic signed [COEFF_WIDTH-1:0]   r_active [C_NUM_COEFF];
    logic signed [COEFF_WIDTH-1:0]   w_coeff_in [C_NUM_COEFF];
    logic signed [DATA_WIDTH-1:0]    r_x, r_x1, r_x2, r_y1, r_y2, r_y;
    logic signed [ACC_W-1:0]         r_acc;
    logic signed [OUT_DATA_WIDTH-1:0] r_y_out;
    logic                            r_y_valid;

    logic                            w_accept;
    logic signed [DATA_WIDTH-1:0]    w_x_sh;
    logic signed [DATA_WIDTH-1:0]    w_mul_a;
    logic signed [COEFF_WIDTH-1:0]   w_mul_b;
    logic signed [PROD_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]         w_prod_ext;
    logic signed [ACC_W-1:0]         w_acc_sh;
    logic signed [PROD_W-1:0]        w_prod_sh;
    logic                            w_y_ovf, w_o_ovf;
    logic signed [DATA_WIDTH-1:0]    w_y_sat, w_y;
    logic signed [OUT_DATA_WIDTH-1:0] w_o_sat, w_out;
    logic                            w_unused_sat;

    assign x_ready       = r_run & (r_state == S_IDLE) & ~r_pending;
    assign coeff_pending = r_pending;
    assign overrun       = r_overrun;
    assign y_out         = r_y_out;
    assign y_valid       = r_y_valid;

    assign w_accept   = x_valid & x_ready;
    assign w_x_sh     = {x_in, {X_SHIFT{1'b0}}};
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_comb begin
        w_coeff_in[C_B0]   = b0;
        w_coeff_in[C_B1]   = b1;
        w_coeff_in[C_B2]   = b2;
        w_coeff_in[C_A1]   = a1;
        w_coeff_in[C_A2]   = a2;
        w_coeff_in[C_GAIN] = gain;
    end

    // Operand steering: one product per MAC step, then y*gain in GAIN
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        if (r_state == S_MAC) begin
            case (r_step)
                3'd0: begin w_mul_a = r_x;  w_mul_b = r_active[C_B0]; end
                3'd1: begin w_mul_a = r_x1; w_mul_b = r_active[C_B1]; end
                3'd2: begin w_mul_a = r_x2; w_mul_b = r_active[C_B2]; end
                3'd3: begin w_mul_a = r_y1; w_mul_b = r_active[C_A1]; end
                3'd4: begin w_mul_a = r_y2; w_mul_b = r_active[C_A2]; end
                default: begin w_mul_a = '0; w_mul_b = '0; end
            endcase
        end else if (r_state == S_GAIN) begin
            w_mul_a = r_y;
            w_mul_b = r_active[C_GAIN];
        end
    end

    iir_shared_mult #(
        .A_WIDTH (DATA_WIDTH),
        .B_WIDTH (COEFF_WIDTH)
    ) u_mult (
        .clk (clk),
        .rst (rst),
        .a   (w_mul_a),
        .b   (w_mul_b),
        .p   (w_prod)
    );

    // Range reduction of the filter state and the gained output
    assign w_acc_sh  = r_acc >>> LOG_A0;
    assign w_y_ovf   = ~((&w_acc_sh[ACC_W-1:DATA_WIDTH-1]) | ~(|w_acc_sh[ACC_W-1:DATA_WIDTH-1]));
    assign w_y_sat   = w_acc_sh[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    assign w_prod_sh = w_prod >>> DATA_WIDTH;
    assign w_o_ovf   = ~((&w_prod_sh[PROD_W-1:OUT_DATA_WIDTH-1]) | ~(|w_prod_sh[PROD_W-1:OUT_DATA_WIDTH-1]));
    assign w_o_sat   = w_prod_sh[PROD_W-1] ? {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};

`ifdef IIR_SAT_EN
    assign w_y   = w_y_ovf ? w_y_sat : w_acc_sh[DATA_WIDTH-1:0];
    assign w_out = w_o_ovf ? w_o_sat : w_prod_sh[OUT_DATA_WIDTH-1:0];
`else
    assign w_y   = w_acc_sh[DATA_WIDTH-1:0];
    assign w_out = w_prod_sh[OUT_DATA_WIDTH-1:0];
`endif
    assign w_unused_sat = ^{w_y_ovf, w_y_sat, w_o_ovf, w_o_sat};

    // Sequencer: MAC runs six steps, the sixth only drains the last product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_step <= '0;
                    if (w_accept) begin
                        r_state <= S_MAC;
                    end else if (r_pending) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: r_state <= S_IDLE;
                S_MAC: begin
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd5) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC:   r_state <= S_GAIN;
                S_GAIN:  r_state <= S_OUT;
                S_OUT:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_y1  <= '0;
            r_y2  <= '0;
            r_y   <= '0;
            r_acc <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= w_x_sh;
                r_acc <= '0;
            end
            if (r_state == S_MAC && r_step != 3'd0) begin
                if (r_step >= 3'd4) begin
                    r_acc <= r_acc - w_prod_ext;
                end else begin
                    r_acc <= r_acc + w_prod_ext;
                end
            end
            // A clear on the accepting edge lands before MAC reads history
            if (r_state == S_IDLE && hist_clr) begin
                r_x1 <= '0;
                r_x2 <= '0;
                r_y1 <= '0;
                r_y2 <= '0;
            end else if (r_state == S_ACC) begin
                r_x2 <= r_x1;
                r_x1 <= r_x;
                r_y2 <= r_y1;
                r_y1 <= w_y;
                r_y  <= w_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= (r_state == S_OUT);
            if (r_state == S_OUT) begin
                r_y_out <= w_out;
            end
        end
    end

    // Active bank only changes in COMMIT, so an in-flight sample never sees it move
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            for (int i = 0; i < C_NUM_COEFF; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (coeff_load) begin
                r_pending <= 1'b1;
            end else if (r_state == S_COMMIT) begin
                r_pending <= 1'b0;
            end
            for (int i = 0; i < C_NUM_COEFF; i++) begin
                if (coeff_load) begin
                    r_shadow[i] <= w_coeff_in[i];
                end
                if (r_state == S_COMMIT) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (x_valid & ~x_ready) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iir_biquad_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_biquad_sequencer
// Brief    : Directed self-checking bench for iir_biquad_sequencer
//            (expected values follow IIR_SAT_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_biquad_sequencer;
    import iir_biquad_sequencer_pkg::*;

    localparam logic signed [31:0] K30   = 32'sh4000_0000;
    localparam logic signed [31:0] K29   = 32'sh2000_0000;
    localparam logic signed [31:0] K28   = 32'sh1000_0000;
    localparam logic signed [31:0] NK29  = 32'shE000_0000;
    localparam logic signed [31:0] KMAX  = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] UNITY = C_UNITY_GAIN;
    localparam logic signed [31:0] HALF  = 32'sh0000_8000;
`ifdef IIR_SAT_EN
    localparam int EXP_BIG = 32767;
`else
    localparam int EXP_BIG = -5537;
`endif

    logic clk = 1'b0;
    logic rst;
    logic signed [15:0] x_in;
    logic x_valid, x_ready;
    logic signed [31:0] b0, b1, b2, a1, a2, gain;
    logic coeff_load, coeff_pending, hist_clr;
    logic signed [15:0] y_out;
    logic y_valid, overrun, ovr_clr;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    iir_biquad_sequencer dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
        .coeff_load(coeff_load), .coeff_pending(coeff_pending), .hist_clr(hist_clr),
        .y_out(y_out), .y_valid(y_valid), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    task automatic load_coeffs(input logic signed [31:0] c0, c1, c2, ca1, ca2, cg);
        @(negedge clk);
        b0 = c0; b1 = c1; b2 = c2; a1 = ca1; a2 = ca2; gain = cg;
        coeff_load = 1'b1;
        @(negedge clk);
        coeff_load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Offers one sample, returns edges from accept to y_valid (0 = never seen)
    task automatic run_sample(input logic signed [15:0] xs, input logic clr,
                              output int lat, output logic signed [15:0] yv);
        @(negedge clk);
        x_in = xs; x_valid = 1'b1; hist_clr = clr;
        @(posedge clk); #1;
        x_valid = 1'b0; hist_clr = 1'b0;
        lat = 0; yv = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (y_valid) begin lat = i; yv = y_out; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; x_in = '0; x_valid = 0; coeff_load = 0; hist_clr = 0; ovr_clr = 0;
        b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0; gain = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (x_ready !== 1'b0) $display("FAIL rst_x_ready got %b exp 0", x_ready); else n_pass++;
        n_chk++; if (y_valid !== 1'b0) $display("FAIL rst_y_valid got %b exp 0", y_valid); else n_pass++;
        n_chk++; if (y_out !== 16'sd0) $display("FAIL rst_y_out got %0d exp 0", y_out); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else n_pass++;
        n_chk++; if (coeff_pending !== 1'b0) $display("FAIL rst_pending got %b exp 0", coeff_pending); else n_pass++;
        rst = 1'b1; #1;
        n_chk++; if (x_ready !== 1'b0) $display("FAIL rel_x_ready_pre got %b exp 0", x_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (x_ready !== 1'b1) $display("FAIL rel_x_ready_post got %b exp 1", x_ready); else n_pass++;
    endtask

    task automatic test_passthrough();
        int lat; logic signed [15:0] yv;
        load_coeffs(K30, 0, 0, 0, 0, UNITY);
        n_chk++; if (coeff_pending !== 1'b0) $display("FAIL pt_pending got %b exp 0", coeff_pending); else n_pass++;
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (lat !== 9) $display("FAIL pt_latency got %0d exp 9", lat); else n_pass++;
        n_chk++; if (yv !== 16'sd1000) $display("FAIL pt_y got %0d exp 1000", yv); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (y_valid !== 1'b0) $display("FAIL pt_strobe_len got %b exp 0", y_valid); else n_pass++;
        n_chk++; if (y_out !== 16'sd1000) $display("FAIL pt_hold got %0d exp 1000", y_out); else n_pass++;
        run_sample(-16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== -16'sd1000) $display("FAIL pt_neg got %0d exp -1000", yv); else n_pass++;
    endtask

    task automatic test_delay_hist_clr();
        int lat; logic signed [15:0] yv;
        load_coeffs(0, K30, 0, 0, 0, UNITY);
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd0) $display("FAIL dly_first got %0d exp 0", yv); else n_pass++;
        run_sample(16'sd0, 1'b0, lat, yv);
        n_chk++; if (yv !== 16'sd1000) $display("FAIL dly_second got %0d exp 1000", yv); else n_pass++;
        run_sample(16'sd1000, 1'b0, lat, yv);
        n_chk++; if (yv !== 16'sd0) $display("FAIL dly_third got %0d exp 0", yv); else n_pass++;
        run_sample(16'sd0, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd0) $display("FAIL clr_with_accept got %0d exp 0", yv); else n_pass++;
    endtask

    task automatic test_recursive();
        int lat; logic signed [15:0] yv;
        int exp_y [4] = '{1000, 500, 250, 125};
        load_coeffs(K30, 0, 0, NK29, 0, UNITY);
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 16'sd1000 : 16'sd0, (i == 0), lat, yv);
            n_chk++; if (yv !== exp_y[i]) $display("FAIL rec_y%0d got %0d exp %0d", i, yv, exp_y[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic signed [15:0] yv;
        load_coeffs(K30, 0, 0, 0, 0, HALF);
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd500) $display("FAIL b2b_gain_half got %0d exp 500", yv); else n_pass++;
        n_chk++; if (x_ready !== 1'b1) $display("FAIL b2b_ready_at_out got %b exp 1", x_ready); else n_pass++;
        run_sample(16'sd2000, 1'b0, lat, yv);
        n_chk++; if (lat !== 9) $display("FAIL b2b_latency got %0d exp 9", lat); else n_pass++;
        n_chk++; if (yv !== 16'sd1000) $display("FAIL b2b_y got %0d exp 1000", yv); else n_pass++;
    endtask

    task automatic test_coeff_update();
        int lat; logic signed [15:0] yv;
        load_coeffs(K30, 0, 0, 0, 0, UNITY);
        @(negedge clk); x_in = 16'sd1000; x_valid = 1'b1; hist_clr = 1'b1;
        @(posedge clk); #1; x_valid = 1'b0; hist_clr = 1'b0;
        @(negedge clk); b0 = K29; coeff_load = 1'b1;
        @(negedge clk); coeff_load = 1'b0;
        n_chk++; if (coeff_pending !== 1'b1) $display("FAIL upd_pending_mac got %b exp 1", coeff_pending); else n_pass++;
        lat = 0; yv = '0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (y_valid) begin lat = i; yv = y_out; break; end
        end
        n_chk++; if (lat !== 9) $display("FAIL upd_latency got %0d exp 9", lat); else n_pass++;
        n_chk++; if (yv !== 16'sd1000) $display("FAIL upd_old_bank got %0d exp 1000", yv); else n_pass++;
        n_chk++; if (x_ready !== 1'b0) $display("FAIL upd_ready_pending got %b exp 0", x_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (x_ready !== 1'b0) $display("FAIL upd_ready_commit got %b exp 0", x_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (coeff_pending !== 1'b0) $display("FAIL upd_pending_done got %b exp 0", coeff_pending); else n_pass++;
        n_chk++; if (x_ready !== 1'b1) $display("FAIL upd_ready_after got %b exp 1", x_ready); else n_pass++;
        run_sample(16'sd1000, 1'b0, lat, yv);
        n_chk++; if (yv !== 16'sd500) $display("FAIL upd_new_bank got %0d exp 500", yv); else n_pass++;
    endtask

    task automatic test_commit_collision();
        int lat; logic signed [15:0] yv;
        @(negedge clk);
        b0 = K30; b1 = '0; b2 = '0; a1 = '0; a2 = '0; gain = UNITY; coeff_load = 1'b1;
        @(negedge clk); coeff_load = 1'b0;
        @(negedge clk);
        n_chk++; if (x_ready !== 1'b0) $display("FAIL col_ready_commit got %b exp 0", x_ready); else n_pass++;
        b0 = K28; coeff_load = 1'b1;
        @(negedge clk); coeff_load = 1'b0;
        n_chk++; if (coeff_pending !== 1'b1) $display("FAIL col_pending_kept got %b exp 1", coeff_pending); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (coeff_pending !== 1'b0) $display("FAIL col_pending_clear got %b exp 0", coeff_pending); else n_pass++;
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd250) $display("FAIL col_new_values got %0d exp 250", yv); else n_pass++;
    endtask

    task automatic test_overrun_sat();
        int lat; logic signed [15:0] yv; int found;
        load_coeffs(KMAX, 0, 0, 0, 0, UNITY);
        run_sample(16'sd30000, 1'b1, lat, yv);
        n_chk++; if (yv !== EXP_BIG) $display("FAIL sat_y got %0d exp %0d", yv, EXP_BIG); else n_pass++;
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_idle got %b exp 0", overrun); else n_pass++;
        @(negedge clk); x_in = 16'sd0; x_valid = 1'b1;
        @(posedge clk); #1; x_valid = 1'b0;
        @(negedge clk); x_valid = 1'b1;
        @(negedge clk); x_valid = 1'b0;
        n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b exp 1", overrun); else n_pass++;
        @(negedge clk); x_valid = 1'b1; ovr_clr = 1'b1;
        @(negedge clk); x_valid = 1'b0; ovr_clr = 1'b0;
        n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b exp 1", overrun); else n_pass++;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (y_valid) begin found = 1; break; end
        end
        n_chk++; if (found !== 1) $display("FAIL ovr_sample_done got %0d exp 1", found); else n_pass++;
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clr got %b exp 0", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; logic signed [15:0] yv; int seen;
        load_coeffs(K30, 0, 0, 0, 0, UNITY);
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd1000) $display("FAIL rm_pre got %0d exp 1000", yv); else n_pass++;
        @(negedge clk); x_in = 16'sd1000; x_valid = 1'b1;
        @(posedge clk); #1; x_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_chk++; if (y_out !== 16'sd0) $display("FAIL rm_y_out got %0d exp 0", y_out); else n_pass++;
        n_chk++; if (x_ready !== 1'b0) $display("FAIL rm_x_ready got %b exp 0", x_ready); else n_pass++;
        @(negedge clk); @(negedge clk); rst = 1'b1; #1;
        n_chk++; if (x_ready !== 1'b0) $display("FAIL rm_ready_pre got %b exp 0", x_ready); else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (y_valid) seen++;
        end
        n_chk++; if (seen !== 0) $display("FAIL rm_no_y_valid got %0d exp 0", seen); else n_pass++;
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (yv !== 16'sd0) $display("FAIL rm_bank_zero got %0d exp 0", yv); else n_pass++;
        load_coeffs(K30, 0, 0, 0, 0, UNITY);
        run_sample(16'sd1000, 1'b1, lat, yv);
        n_chk++; if (lat !== 9) $display("FAIL rm_post_latency got %0d exp 9", lat); else n_pass++;
        n_chk++; if (yv !== 16'sd1000) $display("FAIL rm_post_y got %0d exp 1000", yv); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_delay_hist_clr();
        test_recursive();
        test_back_to_back();
        test_coeff_update();
        test_commit_collision();
        test_overrun_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
